// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// The master side is the fetch unit: it drives the read request and
// presents fetched instructions. The slave side is memory plus decode.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Avalon-MM style instruction-memory read port
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic              i_waitrequest;
  logic [DATA_W-1:0] i_readdata;
  logic              i_readdatavalid;

  // Valid/ready channel towards decode
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output i_address, i_read,
    input  i_waitrequest, i_readdata, i_readdatavalid,
    output instr, instr_pc, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  i_address, i_read,
    output i_waitrequest, i_readdata, i_readdatavalid,
    input  instr, instr_pc, instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues one memory read per fetch
// request, and hands the returned word plus its PC to decode over a
// valid/ready handshake. A PC redirect squashes any in-flight read: the
// read still completes on the bus, but its response is thrown away.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic              busy,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              squash_q, squash_d;

  logic              accept;
  logic              drop;
  logic [ADDR_W-1:0] pc_inc;

  // A request is taken by memory only when it is not stalling us.
  assign accept = (state_q == REQ) && !bus.i_waitrequest;
  // A response is discarded if a redirect happened earlier in this
  // transaction or is happening right now.
  assign drop   = squash_q || pc_load;
  // PC arithmetic wraps naturally at the address width.
  assign pc_inc = pc_q + ADDR_W'(PC_STEP);

  // Next-state and datapath updates; every target gets a hold default first.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    squash_d   = squash_q;

    case (state_q)
      IDLE: begin
        if (fetch) begin
          state_d = REQ;
          // A same-cycle redirect steers this fetch to the new target.
          addr_d  = pc_load ? pc_load_value : pc_q;
        end
      end

      REQ: begin
        // A stalled request keeps its address; the redirect only marks it stale.
        if (pc_load) squash_d = 1'b1;
        if (accept) begin
          if (bus.i_readdatavalid) begin
            // Zero-latency memory: response arrives with the accept.
            if (drop) begin
              squash_d = 1'b0;
              state_d  = IDLE;
            end else begin
              instr_d    = bus.i_readdata;
              instr_pc_d = addr_q;
              valid_d    = 1'b1;
              pc_d       = pc_inc;
              state_d    = HOLD;
            end
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end

      WAIT_DATA: begin
        if (pc_load) squash_d = 1'b1;
        if (bus.i_readdatavalid) begin
          if (drop) begin
            squash_d = 1'b0;
            state_d  = IDLE;
          end else begin
            instr_d    = bus.i_readdata;
            instr_pc_d = addr_q;
            valid_d    = 1'b1;
            pc_d       = pc_inc;
            state_d    = HOLD;
          end
        end
      end

      HOLD: begin
        if (pc_load) begin
          // Redirect wins over a same-cycle handshake: the held word is lost.
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (bus.instr_ready) begin
          valid_d = 1'b0;
          if (fetch) begin
            state_d = REQ;
            addr_d  = pc_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Redirect has priority over any increment made above.
    if (pc_load) pc_d = pc_load_value;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_pc_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      squash_q   <= squash_d;
    end
  end

  assign bus.i_address   = addr_q;
  assign bus.i_read      = (state_q == REQ);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by a
// randomized run against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_value = '0;
  logic        busy;

  logic        fetch2 = 1'b0;
  logic        busy2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus();
  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus2();

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .PC_STEP(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .fetch(fetch), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .busy(busy), .bus(bus)
  );

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .fetch(fetch2), .pc_load(1'b0),
    .pc_load_value(32'h0), .busy(busy2), .bus(bus2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Contents of the instruction memory used by the random run.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // One fetch from IDLE with zero waitstates and one-cycle latency; ends in HOLD.
  task automatic fetch_one(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check({tag, "_read"}, bus.i_read, 1'b1);
    check({tag, "_addr"}, bus.i_address, exp_addr);
    bus.i_waitrequest = 1'b0;
    tick();
    check({tag, "_read_drop"}, bus.i_read, 1'b0);
    bus.i_readdatavalid = 1'b1;
    bus.i_readdata      = data;
    tick();
    bus.i_readdatavalid = 1'b0;
    check({tag, "_valid"}, bus.instr_valid, 1'b1);
    check({tag, "_instr"}, bus.instr, data);
    check({tag, "_ipc"}, bus.instr_pc, exp_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] model_pc;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    logic        stall_prev;
    logic [31:0] stall_addr;
    int          delivered;
    int          accepts;
    int          lat;
    logic        acc;

    bus.i_waitrequest   = 1'b0;
    bus.i_readdata      = '0;
    bus.i_readdatavalid = 1'b0;
    bus.instr_ready     = 1'b0;
    bus2.i_waitrequest   = 1'b0;
    bus2.i_readdata      = '0;
    bus2.i_readdatavalid = 1'b0;
    bus2.instr_ready     = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_read", bus.i_read, 1'b0);
    check("rst_addr", bus.i_address, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_ipc", bus.instr_pc, 32'h0);
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst2_addr", bus2.i_address, 32'hFFFF_FFFC);
    reset_n = 1'b1;
    tick();

    // 1: basic fetch, instr_valid three cycles after the fetch cycle
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check("t1_read", bus.i_read, 1'b1);
    check("t1_addr", bus.i_address, 32'h0);
    check("t1_busy", busy, 1'b1);
    tick();
    check("t1_read_off", bus.i_read, 1'b0);
    check("t1_valid_early", bus.instr_valid, 1'b0);
    bus.i_readdatavalid = 1'b1;
    bus.i_readdata      = 32'h0050_0093;
    tick();
    bus.i_readdatavalid = 1'b0;
    check("t1_valid", bus.instr_valid, 1'b1);
    check("t1_instr", bus.instr, 32'h0050_0093);
    check("t1_ipc", bus.instr_pc, 32'h0);
    bus.instr_ready = 1'b1;
    tick();
    check("t1_valid_clr", bus.instr_valid, 1'b0);
    check("t1_idle", busy, 1'b0);

    // 2: three stall cycles, address stable, exactly one accept
    bus.instr_ready   = 1'b0;
    bus.i_waitrequest = 1'b1;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    accepts = 0;
    for (int k = 0; k < 4; k++) begin
      check("t2_read", bus.i_read, 1'b1);
      check("t2_addr", bus.i_address, 32'h4);
      bus.i_waitrequest = (k < 3);
      if (bus.i_read && !bus.i_waitrequest) accepts++;
      tick();
    end
    check("t2_read_off", bus.i_read, 1'b0);
    check("t2_accepts", accepts, 1);
    bus.i_readdatavalid = 1'b1;
    bus.i_readdata      = 32'h1111_1111;
    tick();
    bus.i_readdatavalid = 1'b0;

    // 3: decode back-pressure, then back-to-back fetch on the handshake
    for (int k = 0; k < 5; k++) begin
      check("t3_valid", bus.instr_valid, 1'b1);
      check("t3_instr", bus.instr, 32'h1111_1111);
      check("t3_ipc", bus.instr_pc, 32'h4);
      tick();
    end
    bus.instr_ready = 1'b1;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    bus.instr_ready = 1'b0;
    check("t3_read", bus.i_read, 1'b1);
    check("t3_addr", bus.i_address, 32'h8);
    check("t3_valid_clr", bus.instr_valid, 1'b0);

    // 4: redirect during WAIT_DATA drops the response
    tick();
    check("t4_wait", busy, 1'b1);
    pc_load = 1'b1;
    pc_load_value = 32'h100;
    tick();
    pc_load = 1'b0;
    bus.i_readdatavalid = 1'b1;
    bus.i_readdata      = 32'hDEAD_BEEF;
    tick();
    bus.i_readdatavalid = 1'b0;
    check("t4_novalid", bus.instr_valid, 1'b0);
    check("t4_idle", busy, 1'b0);
    tick();
    check("t4_novalid2", bus.instr_valid, 1'b0);
    fetch_one("t4_refetch", 32'h100, 32'h2222_2222);

    // 5: redirect in HOLD beats a same-cycle handshake
    pc_load = 1'b1;
    pc_load_value = 32'h200;
    bus.instr_ready = 1'b1;
    tick();
    pc_load = 1'b0;
    bus.instr_ready = 1'b0;
    check("t5_valid_clr", bus.instr_valid, 1'b0);
    check("t5_idle", busy, 1'b0);
    fetch_one("t5_refetch", 32'h200, 32'h3333_3333);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("t5_idle2", busy, 1'b0);

    // 6a: reset pulsed during WAIT_DATA, late response ignored
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    check("t6_wait_busy", busy, 1'b1);
    check("t6_wait_read", bus.i_read, 1'b0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_read", bus.i_read, 1'b0);
    check("t6_rst_addr", bus.i_address, 32'h0);
    check("t6_rst_instr", bus.instr, 32'h0);
    check("t6_rst_ipc", bus.instr_pc, 32'h0);
    check("t6_rst_valid", bus.instr_valid, 1'b0);
    tick();
    reset_n = 1'b1;
    bus.i_readdatavalid = 1'b1;
    bus.i_readdata      = 32'h7777_7777;
    tick();
    bus.i_readdatavalid = 1'b0;
    check("t6_late_valid", bus.instr_valid, 1'b0);
    check("t6_late_busy", busy, 1'b0);
    check("t6_late_instr", bus.instr, 32'h0);

    // 6b: PC wrap from the top of the address space (second instance)
    fetch2 = 1'b1;
    tick();
    fetch2 = 1'b0;
    check("t6_wrap_read", bus2.i_read, 1'b1);
    check("t6_wrap_addr", bus2.i_address, 32'hFFFF_FFFC);
    tick();
    bus2.i_readdatavalid = 1'b1;
    bus2.i_readdata      = 32'h4444_4444;
    tick();
    bus2.i_readdatavalid = 1'b0;
    check("t6_wrap_valid", bus2.instr_valid, 1'b1);
    check("t6_wrap_ipc", bus2.instr_pc, 32'hFFFF_FFFC);
    bus2.instr_ready = 1'b1;
    fetch2 = 1'b1;
    tick();
    fetch2 = 1'b0;
    bus2.instr_ready = 1'b0;
    check("t6_wrap_next", bus2.i_address, 32'h0);

    // Random run: memory with random stalls/latency, random decode and redirects.
    model_pc   = 32'h0;
    pend       = 1'b0;
    pend_addr  = '0;
    pend_cnt   = 0;
    stall_prev = 1'b0;
    stall_addr = '0;
    delivered  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (stall_prev) begin
        check("rnd_stall_read", bus.i_read, 1'b1);
        check("rnd_stall_addr", bus.i_address, stall_addr);
      end
      if (bus.i_read) check("rnd_outstanding", pend, 1'b0);
      if (bus.instr_valid) begin
        check("rnd_ipc", bus.instr_pc, model_pc);
        check("rnd_instr", bus.instr, mem_word(model_pc));
      end

      bus.i_readdatavalid = 1'b0;
      bus.i_readdata      = $urandom;
      if (pend) begin
        if (pend_cnt == 0) begin
          bus.i_readdatavalid = 1'b1;
          bus.i_readdata      = mem_word(pend_addr);
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      bus.i_waitrequest = bus.i_read ? ($urandom_range(0, 2) == 0) : $urandom_range(0, 1);
      acc = bus.i_read && !bus.i_waitrequest;
      if (acc) begin
        lat = $urandom_range(0, 2);
        if (lat == 0 && !bus.i_readdatavalid) begin
          bus.i_readdatavalid = 1'b1;
          bus.i_readdata      = mem_word(bus.i_address);
        end else begin
          pend      = 1'b1;
          pend_addr = bus.i_address;
          pend_cnt  = (lat == 0) ? 0 : lat - 1;
        end
      end else if (!bus.i_readdatavalid && !pend && (!busy || bus.instr_valid)
                   && $urandom_range(0, 3) == 0) begin
        bus.i_readdatavalid = 1'b1;
      end
      fetch           = $urandom_range(0, 1);
      bus.instr_ready = $urandom_range(0, 1);
      pc_load         = ($urandom_range(0, 15) == 0);
      pc_load_value   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      stall_prev      = bus.i_read && bus.i_waitrequest;
      stall_addr      = bus.i_address;

      if (pc_load) begin
        model_pc = pc_load_value;
      end else if (bus.instr_valid && bus.instr_ready) begin
        model_pc = model_pc + 32'd4;
        delivered++;
      end
      tick();
    end
    check("rnd_progress", (delivered >= 100), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
